btb_gshare_predictor: RTL

//  Next-generation branch predictor for the IF stage: tagged, direct-mapped BTB plus a

---
 rtl/btb_gshare_predictor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/btb_gshare_predictor.sv
// btb_gshare_predictor
//   Fetch-stage branch predictor: a tagged, direct-mapped BTB plus a table of
//   saturating direction counters. Prediction is purely combinational from
//   registered state. The EX stage returns resolved branches on the feedback
//   port, and the tables see those updates from the following cycle.
//
//   Optional feature macro: BP_GSHARE_EN
//     defined   - the counter index is the PC index XOR global history; a
//                 non-speculative GHR is kept and exported on pre_ghr_o.
//     undefined - bimodal indexing; there are no GHR flops, pre_ghr_o is 0
//                 and set_ghr_i is ignored.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   pc_i                fetch PC to predict
//   pre_hit_o           BTB tag hit for pc_i
//   pre_take_o          predict taken
//   pre_destination_o   predicted target (0 on miss)
//   pre_ghr_o           history used for this prediction
//   feedback_valid_i    resolved-branch update strobe
//   set_pc_i            PC of the resolved branch
//   set_taken_i         actual direction
//   set_target_i        actual target
//   set_ghr_i           pre_ghr_o value that travelled with the branch
module btb_gshare_predictor #(
    parameter int PCW  = 31,
    parameter int IDXW = 5,
    parameter int TAGW = 8,
    parameter int CNTW = 2,
    parameter int GHRW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PCW-1:0]  pc_i,
    output logic            pre_hit_o,
    output logic            pre_take_o,
    output logic [PCW-1:0]  pre_destination_o,
    output logic [GHRW-1:0] pre_ghr_o,
    input  logic            feedback_valid_i,
    input  logic [PCW-1:0]  set_pc_i,
    input  logic            set_taken_i,
    input  logic [PCW-1:0]  set_target_i,
    input  logic [GHRW-1:0] set_ghr_i
);

    localparam int ENTRIES = 1 << IDXW;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'((1 << (CNTW - 1)) - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    logic            r_valid  [ENTRIES];
    logic [TAGW-1:0] r_tag    [ENTRIES];
    logic [PCW-1:0]  r_target [ENTRIES];
    logic [CNTW-1:0] r_cnt    [ENTRIES];

    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;
    logic [IDXW-1:0] w_cidx;
    logic [IDXW-1:0] w_set_idx;
    logic [TAGW-1:0] w_set_tag;
    logic [IDXW-1:0] w_set_cidx;
    logic [IDXW-1:0] w_ghr_ext;
    logic [IDXW-1:0] w_set_ghr_ext;
    logic [CNTW-1:0] w_set_cnt;
    logic [CNTW-1:0] w_cnt_next;
    logic            w_hit;
    logic            w_unused;

    assign w_idx     = pc_i[IDXW-1:0];
    assign w_tag     = pc_i[IDXW+TAGW-1:IDXW];
    assign w_set_idx = set_pc_i[IDXW-1:0];
    assign w_set_tag = set_pc_i[IDXW+TAGW-1:IDXW];

`ifdef BP_GSHARE_EN
    logic [GHRW-1:0] r_ghr;

    // History is shifted only on resolved branches, so it never needs repair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (feedback_valid_i) begin
            r_ghr <= {r_ghr[GHRW-2:0], set_taken_i};
        end
    end

    assign w_ghr_ext     = IDXW'(r_ghr);
    assign w_set_ghr_ext = IDXW'(set_ghr_i);
    assign pre_ghr_o     = r_ghr;
    assign w_unused      = ^{pc_i, set_pc_i};
`else
    assign w_ghr_ext     = '0;
    assign w_set_ghr_ext = '0;
    assign pre_ghr_o     = '0;
    assign w_unused      = ^{pc_i, set_pc_i, set_ghr_i};
`endif

    // The update uses the history carried with the branch, not the current
    // GHR, so it trains the same counter that produced the prediction.
    assign w_cidx     = w_idx ^ w_ghr_ext;
    assign w_set_cidx = w_set_idx ^ w_set_ghr_ext;

    assign w_hit             = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign pre_hit_o         = w_hit;
    assign pre_take_o        = w_hit && r_cnt[w_cidx][CNTW-1];
    assign pre_destination_o = w_hit ? r_target[w_idx] : '0;

    assign w_set_cnt = r_cnt[w_set_cidx];

    always_comb begin
        w_cnt_next = w_set_cnt;
        if (set_taken_i) begin
            if (w_set_cnt != CNT_MAX) w_cnt_next = w_set_cnt + CNTW'(1);
        end else begin
            if (w_set_cnt != '0) w_cnt_next = w_set_cnt - CNTW'(1);
        end
    end

    // Counters train on every resolved branch; the BTB only learns taken ones,
    // overwriting whatever alias currently owns the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_INIT;
            end
        end else if (feedback_valid_i) begin
            r_cnt[w_set_cidx] <= w_cnt_next;
            if (set_taken_i) begin
                r_valid[w_set_idx]  <= 1'b1;
                r_tag[w_set_idx]    <= w_set_tag;
                r_target[w_set_idx] <= set_target_i;
            end
        end
    end

endmodule
